// File: rtl/stride_prefetcher.sv
// PC-indexed stride prefetcher: reference prediction table plus a DEGREE-deep request engine.
// Optional macro PF_DEDUP_EN suppresses candidates that match the last DEGREE granted addresses.
module stride_prefetcher #(
  parameter int ADDR_W  = 16,
  parameter int ENTRIES = 32,
  parameter int TAG_W   = 6,
  parameter int DEGREE  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       pc,
  input  logic              memAccess,
  input  logic [ADDR_W-1:0] memAddress,
  input  logic              memGrant,
  output logic              memRequest,
  output logic [ADDR_W-1:0] requestAddress,
  output logic              prefetchBusy
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(DEGREE + 1);

  typedef enum logic [1:0] {ST_INIT, ST_TRANS, ST_STEADY, ST_NOPRED} conf_t;
  typedef enum logic {E_IDLE, E_ISSUE} eng_t;

  logic              rpt_valid_q  [ENTRIES];
  logic [TAG_W-1:0]  rpt_tag_q    [ENTRIES];
  logic [ADDR_W-1:0] rpt_prev_q   [ENTRIES];
  logic [ADDR_W-1:0] rpt_stride_q [ENTRIES];
  conf_t             rpt_conf_q   [ENTRIES];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic              correct;
  logic              trigger;
  logic [ADDR_W-1:0] delta;
  logic [ADDR_W-1:0] stride_d;
  conf_t             conf_d;

  assign idx = pc[IDX_W-1:0];
  assign tag = pc[IDX_W+TAG_W-1:IDX_W];

  generate
    if (IDX_W + TAG_W < 16) begin : g_pc_hi
      logic pc_hi_unused;
      assign pc_hi_unused = ^pc[15:IDX_W+TAG_W];
    end
  endgenerate

  // Lookup and training decision
  always_comb begin
    hit      = rpt_valid_q[idx] && (rpt_tag_q[idx] == tag);
    delta    = memAddress - rpt_prev_q[idx];
    correct  = (delta == rpt_stride_q[idx]);
    stride_d = rpt_stride_q[idx];
    conf_d   = rpt_conf_q[idx];
    case (rpt_conf_q[idx])
      ST_INIT:   if (correct) conf_d = ST_STEADY; else begin conf_d = ST_TRANS;  stride_d = delta; end
      ST_TRANS:  if (correct) conf_d = ST_STEADY; else begin conf_d = ST_NOPRED; stride_d = delta; end
      ST_STEADY: if (!correct) conf_d = ST_INIT;
      default:   if (correct) conf_d = ST_TRANS;  else begin conf_d = ST_NOPRED; stride_d = delta; end
    endcase
    trigger = memAccess && hit && (conf_d == ST_STEADY) && (stride_d != '0);
  end

  // RPT update stage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        rpt_valid_q[i]  <= 1'b0;
        rpt_tag_q[i]    <= '0;
        rpt_prev_q[i]   <= '0;
        rpt_stride_q[i] <= '0;
        rpt_conf_q[i]   <= ST_INIT;
      end
    end else if (memAccess) begin
      rpt_valid_q[idx]  <= 1'b1;
      rpt_tag_q[idx]    <= tag;
      rpt_prev_q[idx]   <= memAddress;
      rpt_stride_q[idx] <= hit ? stride_d : '0;
      rpt_conf_q[idx]   <= hit ? conf_d : ST_INIT;
    end
  end

  eng_t              eng_q, eng_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] estride_q, estride_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              advance;
`ifdef PF_DEDUP_EN
  logic [ADDR_W-1:0] hist_q [DEGREE];
  logic [ADDR_W-1:0] hist_d [DEGREE];
  logic              hist_vld_q [DEGREE];
  logic              hist_vld_d [DEGREE];
  logic              dup;
`endif

  // Request engine next state
  always_comb begin
    eng_d     = eng_q;
    cur_d     = cur_q;
    estride_d = estride_q;
    cnt_d     = cnt_q;
    advance   = 1'b0;
`ifdef PF_DEDUP_EN
    hist_d     = hist_q;
    hist_vld_d = hist_vld_q;
    dup        = 1'b0;
`endif
    case (eng_q)
      E_IDLE: begin
        if (trigger) begin
          eng_d     = E_ISSUE;
          cur_d     = memAddress + stride_d;
          estride_d = stride_d;
          cnt_d     = CNT_W'(DEGREE);
        end
      end
      default: begin
        // A cycle with no request outstanding is a skipped duplicate and always advances.
        advance = req_q ? memGrant : 1'b1;
        if (advance) begin
          cur_d = cur_q + estride_q;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) eng_d = E_IDLE;
        end
      end
    endcase
`ifdef PF_DEDUP_EN
    if ((eng_q == E_ISSUE) && req_q && memGrant) begin
      for (int i = DEGREE - 1; i > 0; i--) begin
        hist_d[i]     = hist_q[i-1];
        hist_vld_d[i] = hist_vld_q[i-1];
      end
      hist_d[0]     = cur_q;
      hist_vld_d[0] = 1'b1;
    end
    for (int i = 0; i < DEGREE; i++) begin
      if (hist_vld_d[i] && (hist_d[i] == cur_d)) dup = 1'b1;
    end
    req_d = (eng_d == E_ISSUE) && !dup;
`else
    req_d = (eng_d == E_ISSUE);
`endif
  end

  // Engine register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      eng_q     <= E_IDLE;
      cur_q     <= '0;
      estride_q <= '0;
      cnt_q     <= '0;
      req_q     <= 1'b0;
`ifdef PF_DEDUP_EN
      for (int i = 0; i < DEGREE; i++) begin
        hist_q[i]     <= '0;
        hist_vld_q[i] <= 1'b0;
      end
`endif
    end else begin
      eng_q     <= eng_d;
      cur_q     <= cur_d;
      estride_q <= estride_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
`ifdef PF_DEDUP_EN
      hist_q     <= hist_d;
      hist_vld_q <= hist_vld_d;
`endif
    end
  end

  assign memRequest     = req_q;
  assign requestAddress = cur_q;
  assign prefetchBusy   = (eng_q == E_ISSUE);

endmodule

// File: tb/tb_stride_prefetcher.sv
// Directed bench for stride_prefetcher: a vector table for training/issue/stall/wrap/conflict,
// plus hand sequences for busy-drop and reset during a burst.
module tb_stride_prefetcher;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic        memAccess;
  logic [15:0] memAddress;
  logic        memGrant;
  logic        memRequest;
  logic [15:0] requestAddress;
  logic        prefetchBusy;

  int total = 0;
  int bad   = 0;

  stride_prefetcher #(.ADDR_W(16), .ENTRIES(32), .TAG_W(6), .DEGREE(2)) dut (
    .clk(clk), .rst(rst), .pc(pc), .memAccess(memAccess), .memAddress(memAddress),
    .memGrant(memGrant), .memRequest(memRequest), .requestAddress(requestAddress),
    .prefetchBusy(prefetchBusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] pc;
    logic        acc;
    logic [15:0] addr;
    logic        gnt;
    logic        req;
    logic        chk_a;
    logic [15:0] ra;
    logic        busy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [15:0] p, input logic a, input logic [15:0] ad,
                     input logic g, input logic q, input logic ca, input logic [15:0] ra,
                     input logic b);
    vec_t v;
    v.rst = r; v.pc = p; v.acc = a; v.addr = ad; v.gnt = g;
    v.req = q; v.chk_a = ca; v.ra = ra; v.busy = b;
    vq.push_back(v);
  endtask

  task automatic add_rst();
    add(1'b1, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 16'h0, 1'b0);
  endtask

  task automatic add_acc(input logic [15:0] p, input logic [15:0] ad, input logic g,
                         input logic q, input logic [15:0] ra, input logic b);
    add(1'b0, p, 1'b1, ad, g, q, q, ra, b);
  endtask

  task automatic add_idle(input logic g, input logic q, input logic [15:0] ra, input logic b);
    add(1'b0, 16'h0040, 1'b0, 16'h0, g, q, q, ra, b);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [15:0] p, input logic a, input logic [15:0] ad,
                      input logic g);
    rst = r; pc = p; memAccess = a; memAddress = ad; memGrant = g;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pc = 16'h0; memAccess = 1'b0; memAddress = 16'h0; memGrant = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Train and issue two prefetches
    add_rst();
    add_acc(16'h0040, 16'h0100, 1'b1, 1'b0, 16'h0, 1'b0);
    add_acc(16'h0040, 16'h0104, 1'b1, 1'b0, 16'h0, 1'b0);
    add_acc(16'h0040, 16'h0108, 1'b1, 1'b1, 16'h010C, 1'b1);
    add_idle(1'b1, 1'b1, 16'h0110, 1'b1);
    add_idle(1'b1, 1'b0, 16'h0, 1'b0);
    // Continue the stream: overlapping candidate
`ifdef PF_DEDUP_EN
    add_acc(16'h0040, 16'h010C, 1'b1, 1'b0, 16'h0, 1'b1);
    add_idle(1'b1, 1'b1, 16'h0114, 1'b1);
    add_idle(1'b1, 1'b0, 16'h0, 1'b0);
`else
    add_acc(16'h0040, 16'h010C, 1'b1, 1'b1, 16'h0110, 1'b1);
    add_idle(1'b1, 1'b1, 16'h0114, 1'b1);
    add_idle(1'b1, 1'b0, 16'h0, 1'b0);
`endif
    // Stall: grant withheld for three cycles
    add_rst();
    add_acc(16'h0040, 16'h0100, 1'b0, 1'b0, 16'h0, 1'b0);
    add_acc(16'h0040, 16'h0104, 1'b0, 1'b0, 16'h0, 1'b0);
    add_acc(16'h0040, 16'h0108, 1'b0, 1'b1, 16'h010C, 1'b1);
    add_idle(1'b0, 1'b1, 16'h010C, 1'b1);
    add_idle(1'b0, 1'b1, 16'h010C, 1'b1);
    add_idle(1'b0, 1'b1, 16'h010C, 1'b1);
    add_idle(1'b1, 1'b1, 16'h0110, 1'b1);
    add_idle(1'b1, 1'b0, 16'h0, 1'b0);
    // Negative stride across zero
    add_rst();
    add_acc(16'h0040, 16'h0008, 1'b1, 1'b0, 16'h0, 1'b0);
    add_acc(16'h0040, 16'h0004, 1'b1, 1'b0, 16'h0, 1'b0);
    add_acc(16'h0040, 16'h0000, 1'b1, 1'b1, 16'hFFFC, 1'b1);
    add_idle(1'b1, 1'b1, 16'hFFF8, 1'b1);
    add_idle(1'b1, 1'b0, 16'h0, 1'b0);
    // Conflict: 0x0440 has index 0 like 0x0040 but differs in tag bit pc[10]
    add_rst();
    add_acc(16'h0040, 16'h0100, 1'b1, 1'b0, 16'h0, 1'b0);
    add_acc(16'h0040, 16'h0104, 1'b1, 1'b0, 16'h0, 1'b0);
    add_acc(16'h0040, 16'h0108, 1'b1, 1'b1, 16'h010C, 1'b1);
    add_idle(1'b1, 1'b1, 16'h0110, 1'b1);
    add_idle(1'b1, 1'b0, 16'h0, 1'b0);
    add_acc(16'h0440, 16'h010C, 1'b1, 1'b0, 16'h0, 1'b0);
    add_acc(16'h0040, 16'h0110, 1'b1, 1'b0, 16'h0, 1'b0);
    add_acc(16'h0040, 16'h0114, 1'b1, 1'b0, 16'h0, 1'b0);
    add_acc(16'h0040, 16'h0118, 1'b1, 1'b1, 16'h011C, 1'b1);
    add_idle(1'b1, 1'b1, 16'h0120, 1'b1);
    add_idle(1'b1, 1'b0, 16'h0, 1'b0);

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].pc, vq[i].acc, vq[i].addr, vq[i].gnt);
      chk($sformatf("v%0d_req", i), {15'h0, memRequest}, {15'h0, vq[i].req});
      chk($sformatf("v%0d_busy", i), {15'h0, prefetchBusy}, {15'h0, vq[i].busy});
      if (vq[i].chk_a) chk($sformatf("v%0d_addr", i), requestAddress, vq[i].ra);
    end

    // Trigger while busy is dropped, but the RPT still trains
    step(1'b1, 16'h0040, 1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0040, 1'b1, 16'h0100, 1'b0);
    step(1'b0, 16'h0040, 1'b1, 16'h0104, 1'b0);
    step(1'b0, 16'h0040, 1'b1, 16'h0108, 1'b0);
    step(1'b0, 16'h0040, 1'b1, 16'h010C, 1'b0);
    chk("drop_req", {15'h0, memRequest}, 16'h1);
    chk("drop_addr", requestAddress, 16'h010C);
    step(1'b0, 16'h0040, 1'b0, 16'h0, 1'b1);
    chk("drop_2nd", requestAddress, 16'h0110);
    step(1'b0, 16'h0040, 1'b0, 16'h0, 1'b1);
    chk("drop_idle", {15'h0, prefetchBusy}, 16'h0);
    step(1'b0, 16'h0040, 1'b1, 16'h0110, 1'b1);
    chk("retrig_addr", requestAddress, 16'h0114);
    chk("retrig_req", {15'h0, memRequest}, 16'h1);

    // Reset mid-burst, with a grant and access presented in the same cycle
    step(1'b1, 16'h0040, 1'b1, 16'h0118, 1'b1);
    chk("rst_req", {15'h0, memRequest}, 16'h0);
    chk("rst_busy", {15'h0, prefetchBusy}, 16'h0);
    chk("rst_addr", requestAddress, 16'h0000);
    step(1'b0, 16'h0040, 1'b0, 16'h0, 1'b1);
    chk("rst_quiet", {15'h0, memRequest}, 16'h0);
    // Trained entry was wiped: these must behave as miss then INIT->TRANSIENT
    step(1'b0, 16'h0040, 1'b1, 16'h0114, 1'b1);
    chk("rst_miss", {15'h0, memRequest}, 16'h0);
    step(1'b0, 16'h0040, 1'b1, 16'h0118, 1'b1);
    chk("rst_init", {15'h0, memRequest}, 16'h0);
    step(1'b0, 16'h0040, 1'b1, 16'h011C, 1'b1);
    begin
      int waited = 0;
      while (!memRequest && waited < 10) begin
        step(1'b0, 16'h0040, 1'b0, 16'h0, 1'b1);
        waited++;
      end
      chk("retrain_wait", {15'h0, memRequest}, 16'h1);
      chk("retrain_lat", waited[15:0], 16'h0);
      chk("retrain_addr", requestAddress, 16'h0120);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
